mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port unified SRAM between three core requesters: instruction fetch, data read and data write.
- Sits between the riscv core's imem/dmem ports and the memory macro. It replaces the two separate mem2ports instances when the design uses one unified RAM.
- Fixed-priority arbitration, with an anti-starvation counter for instruction fetch.
- Tags each read in a latency pipeline so read data returns to the port that issued it.

Parameters:
- AW, 15: memory word-address width. Memory covers 2^(AW+2) bytes.
- RD_LAT, 1: memory read latency in cycles, 1 to 4.
- WAIT_MAX, 4: number of consecutive denied imem cycles after which imem takes top priority.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- imem_ready  in  1  fetch request; held with imem_addr until granted
- imem_valid  out  1  fetch grant, same cycle as request
- imem_addr  in  32  fetch byte address
- imem_rresp  out  1  fetch data valid pulse
- imem_rdata  out  32  fetch data
- dmem_rready  in  1  load request
- dmem_rvalid  out  1  load grant
- dmem_raddr  in  32  load byte address
- dmem_rresp  out  1  load data valid pulse
- dmem_rdata  out  32  load data
- dmem_wready  in  1  store request
- dmem_wvalid  out  1  store grant
- dmem_waddr  in  32  store byte address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  store byte strobes
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  AW  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_wstrb  out  4  SRAM byte strobes
- mem_rdata  in  32  SRAM read data, valid RD_LAT cycles after a read enable
- err  out  1  out-of-range access pulse

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- While reset is high:
  - All grants, rresp and err outputs are 0; mem_en=0, mem_we=0.
  - The tag pipeline and the starvation counter are cleared.
  - Reset mid-operation discards in-flight reads; no rresp is ever issued for them.
- Arbitration is combinational. At most one grant per cycle. A grant is a completed transfer at the next posedge.
  - Normal order: dmem write > dmem read > imem.
  - Starved order, when starve_cnt == WAIT_MAX: imem > dmem write > dmem read.
- Starvation counter starve_cnt, width clog2(WAIT_MAX+1):
  - Increments when imem_ready=1 and imem is not granted; saturates at WAIT_MAX.
  - Clears on an imem grant, or when imem_ready=0.
- Address mapping: mem_addr = granted_addr[AW+1:2]. mem_wdata and mem_wstrb pass through from the dmem store port.
- Out-of-range access: any of granted_addr[31:AW+2] is nonzero.
  - The request is still granted, so the core never deadlocks.
  - mem_en is held at 0 and err pulses high in the grant cycle.
  - For a read, the tag is still issued; rresp occurs at the normal latency with rdata=0.
- Read tag pipeline: RD_LAT stages, each holding {valid, src (0=imem, 1=dmem), oor}, shifting every cycle.
  - At the last stage with valid=1, the matching *_rresp is 1 for exactly one cycle.
  - Matching *_rdata = oor ? 0 : mem_rdata.
  - Non-matching rdata outputs are 0; rdata is 0 whenever rresp is 0.
- Throughput: a read can be granted every cycle, including back-to-back reads from different sources. Responses return in grant order.
- A write granted in the same cycle as an outstanding read's response is legal; the SRAM port is free for one access per cycle.
- Ports are independent: requests on different ports never combine. Requester address or data changes while not granted are ignored.

Test Plan:
- Reset, then imem_ready=1, imem_addr=0x0000_0010 with mem_rdata=0x1234_5678 at the return cycle -> imem_valid=1 same cycle; mem_en=1, mem_we=0, mem_addr=4; imem_rresp=1 and imem_rdata=0x1234_5678 one cycle later (RD_LAT=1).
- All three requests held high -> grant order store, load, store... while imem is denied. imem is granted on the cycle after it has been denied 4 cycles (starve_cnt==4), then starve_cnt=0.
- Store dmem_waddr=0x0000_0104, wdata=0xAABB_CCDD, wstrb=4'b0011 -> mem_we=1, mem_addr=0x41, mem_wstrb=4'b0011, dmem_wvalid=1, err=0.
- Load dmem_raddr=0x8000_001C (out of range for AW=15) -> dmem_rvalid=1, mem_en=0, err=1 for one cycle; dmem_rresp=1 with dmem_rdata=0 after RD_LAT.
- RD_LAT=3: alternate imem/dmem read grants on 4 consecutive cycles -> rresp pulses on cycles 3..6 with sources imem, dmem, imem, dmem and the correct per-address data.
- Assert reset one cycle after 2 reads are granted (RD_LAT=3) -> no rresp ever appears; all outputs are 0 during reset; normal operation resumes after reset is released.

Source files
------------

// File: rtl/mem_arbiter.sv
// Unified single-port SRAM arbiter for instruction fetch, data load and data store.
// Fixed priority store > load > fetch, with fetch promoted to top priority after
// WAIT_MAX consecutive denied cycles. Reads carry a tag down a latency pipeline
// so returning data is steered to the port that issued it.
module mem_arbiter #(
  parameter int unsigned AW       = 15,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned WAIT_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  // instruction fetch
  input  logic          imem_ready,
  output logic          imem_valid,
  input  logic [31:0]   imem_addr,
  output logic          imem_rresp,
  output logic [31:0]   imem_rdata,
  // data load
  input  logic          dmem_rready,
  output logic          dmem_rvalid,
  input  logic [31:0]   dmem_raddr,
  output logic          dmem_rresp,
  output logic [31:0]   dmem_rdata,
  // data store
  input  logic          dmem_wready,
  output logic          dmem_wvalid,
  input  logic [31:0]   dmem_waddr,
  input  logic [31:0]   dmem_wdata,
  input  logic [3:0]    dmem_wstrb,
  // SRAM macro
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [31:0]   mem_rdata,
  output logic          err
);

  localparam int unsigned SW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef struct packed {
    logic valid;
    logic src;   // 0 = imem, 1 = dmem
    logic oor;
  } tag_t;

  logic [SW-1:0] starve_cnt;
  logic          starved;
  logic          gnt_i;
  logic          gnt_r;
  logic          gnt_w;
  logic          any_gnt;
  logic [31:0]   gaddr;
  logic          oor;
  tag_t          pipe [RD_LAT];
  tag_t          last;
  logic [31:0]   ret_data;
  logic          unused_addr_bits;

  assign starved = (starve_cnt == SW'(WAIT_MAX));

  // Grant selection; the starved fetch jumps ahead of both data ports
  always_comb begin
    gnt_i = 1'b0;
    gnt_r = 1'b0;
    gnt_w = 1'b0;
    if (!reset) begin
      if (starved && imem_ready) gnt_i = 1'b1;
      else if (dmem_wready)      gnt_w = 1'b1;
      else if (dmem_rready)      gnt_r = 1'b1;
      else if (imem_ready)       gnt_i = 1'b1;
    end
  end

  // Address of the winning port and its range check
  always_comb begin
    gaddr = 32'h0;
    if (gnt_w)      gaddr = dmem_waddr;
    else if (gnt_r) gaddr = dmem_raddr;
    else if (gnt_i) gaddr = imem_addr;
  end

  assign oor              = ((gaddr >> (AW + 2)) != 32'h0);
  assign any_gnt          = gnt_i | gnt_r | gnt_w;
  assign unused_addr_bits = ^gaddr[1:0];

  assign imem_valid  = gnt_i;
  assign dmem_rvalid = gnt_r;
  assign dmem_wvalid = gnt_w;

  // SRAM drive; out-of-range accesses are granted but never reach the macro
  assign mem_en    = any_gnt & ~oor;
  assign mem_we    = gnt_w & ~oor;
  assign mem_addr  = gaddr[AW+1:2];
  assign mem_wdata = dmem_wdata;
  assign mem_wstrb = dmem_wstrb;
  assign err       = any_gnt & oor;

  // Fetch starvation counter: counts consecutive denied fetch cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!imem_ready || gnt_i) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // Read tag pipeline, aligned with the SRAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: gnt_i | gnt_r, src: gnt_r, oor: oor};
      for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last = pipe[RD_LAT-1];

  // Response steering; rdata stays zero on the port not being answered
  always_comb begin
    ret_data   = last.oor ? 32'h0 : mem_rdata;
    imem_rresp = last.valid & ~last.src;
    dmem_rresp = last.valid & last.src;
    imem_rdata = imem_rresp ? ret_data : 32'h0;
    dmem_rdata = dmem_rresp ? ret_data : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=3,
// each backed by a simple SRAM model returning 0x1234_5674 + word address.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // RD_LAT=1 instance signals
  logic        reset1;
  logic        ir1, iv1, irr1, rr1, rv1, drr1, wr1, wv1;
  logic [31:0] ia1, ird1, ra1, drd1, wa1, wd1;
  logic [3:0]  ws1;
  logic        en1, we1, err1;
  logic [14:0] ma1;
  logic [31:0] mwd1;
  logic [3:0]  mws1;
  logic [31:0] mrd1 = 32'hDEAD_BEEF;

  // RD_LAT=3 instance signals
  logic        reset3;
  logic        ir3, iv3, irr3, rr3, rv3, drr3, wr3, wv3;
  logic [31:0] ia3, ird3, ra3, drd3, wa3, wd3;
  logic [3:0]  ws3;
  logic        en3, we3, err3;
  logic [14:0] ma3;
  logic [31:0] mwd3;
  logic [3:0]  mws3;
  logic [31:0] p3 [3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

  mem_arbiter #(.AW(15), .RD_LAT(1), .WAIT_MAX(4)) dut1 (
    .clk(clk), .reset(reset1),
    .imem_ready(ir1), .imem_valid(iv1), .imem_addr(ia1), .imem_rresp(irr1), .imem_rdata(ird1),
    .dmem_rready(rr1), .dmem_rvalid(rv1), .dmem_raddr(ra1), .dmem_rresp(drr1), .dmem_rdata(drd1),
    .dmem_wready(wr1), .dmem_wvalid(wv1), .dmem_waddr(wa1), .dmem_wdata(wd1), .dmem_wstrb(ws1),
    .mem_en(en1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(mwd1), .mem_wstrb(mws1),
    .mem_rdata(mrd1), .err(err1)
  );

  mem_arbiter #(.AW(15), .RD_LAT(3), .WAIT_MAX(4)) dut3 (
    .clk(clk), .reset(reset3),
    .imem_ready(ir3), .imem_valid(iv3), .imem_addr(ia3), .imem_rresp(irr3), .imem_rdata(ird3),
    .dmem_rready(rr3), .dmem_rvalid(rv3), .dmem_raddr(ra3), .dmem_rresp(drr3), .dmem_rdata(drd3),
    .dmem_wready(wr3), .dmem_wvalid(wv3), .dmem_waddr(wa3), .dmem_wdata(wd3), .dmem_wstrb(ws3),
    .mem_en(en3), .mem_we(we3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_wstrb(mws3),
    .mem_rdata(p3[2]), .err(err3)
  );

  // SRAM models: valid data only in the return cycle, garbage otherwise
  always @(posedge clk) begin
    mrd1  <= (en1 && !we1) ? 32'h1234_5674 + 32'(ma1) : 32'hDEAD_BEEF;
    p3[0] <= (en3 && !we3) ? 32'h1234_5674 + 32'(ma3) : 32'hDEAD_BEEF;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] t5_addr [4] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300, 32'h0000_0400};
  logic [31:0] t5_data [4] = '{32'h1234_56B4, 32'h1234_56F4, 32'h1234_5734, 32'h1234_5774};

  initial begin
    reset1 = 1'b1; reset3 = 1'b1;
    ir1 = 1'b1; rr1 = 1'b0; wr1 = 1'b0; ia1 = 32'h10; ra1 = '0; wa1 = '0; wd1 = '0; ws1 = '0;
    ir3 = 1'b1; rr3 = 1'b0; wr3 = 1'b0; ia3 = 32'h10; ra3 = '0; wa3 = '0; wd3 = '0; ws3 = '0;

    // Reset: requests present but nothing granted
    cyc(); #3;
    check("rst_ivalid", 32'(iv1), 0);
    check("rst_en",     32'(en1), 0);
    check("rst_we",     32'(we1), 0);
    check("rst_err",    32'(err1), 0);
    check("rst_irresp", 32'(irr1), 0);

    // Basic fetch, RD_LAT=1
    cyc(); reset1 = 1'b0; ir1 = 1'b1; ia1 = 32'h0000_0010; #3;
    check("f_ivalid", 32'(iv1), 1);
    check("f_en",     32'(en1), 1);
    check("f_we",     32'(we1), 0);
    check("f_addr",   32'(ma1), 32'h4);
    check("f_rresp0", 32'(irr1), 0);
    cyc(); ir1 = 1'b0; #3;
    check("f_rresp",  32'(irr1), 1);
    check("f_rdata",  ird1, 32'h1234_5678);
    check("f_drresp", 32'(drr1), 0);
    check("f_drdata", drd1, 0);
    cyc(); #3;
    check("f_rresp_end", 32'(irr1), 0);
    check("f_rdata_end", ird1, 0);

    // Priority and starvation, with store details on the first cycle
    cyc(); ir1 = 1'b1; wr1 = 1'b1; rr1 = 1'b1;
    wa1 = 32'h0000_0104; wd1 = 32'hAABB_CCDD; ws1 = 4'b0011; ra1 = 32'h0000_0020; #3;
    check("s0_wvalid", 32'(wv1), 1);
    check("s0_rvalid", 32'(rv1), 0);
    check("s0_ivalid", 32'(iv1), 0);
    check("st_we",     32'(we1), 1);
    check("st_addr",   32'(ma1), 32'h41);
    check("st_wstrb",  32'(mws1), 32'h3);
    check("st_wdata",  mwd1, 32'hAABB_CCDD);
    check("st_err",    32'(err1), 0);
    cyc(); wr1 = 1'b0; #3;
    check("s1_rvalid", 32'(rv1), 1);
    check("s1_wvalid", 32'(wv1), 0);
    check("s1_ivalid", 32'(iv1), 0);
    check("s1_addr",   32'(ma1), 32'h8);
    cyc(); wr1 = 1'b1; #3;
    check("s2_wvalid", 32'(wv1), 1);
    check("s2_drresp", 32'(drr1), 1);
    check("s2_drdata", drd1, 32'h1234_567C);
    check("s2_irresp", 32'(irr1), 0);
    cyc(); #3;
    check("s3_wvalid", 32'(wv1), 1);
    check("s3_ivalid", 32'(iv1), 0);
    cyc(); #3;
    check("s4_ivalid", 32'(iv1), 1);
    check("s4_wvalid", 32'(wv1), 0);
    check("s4_rvalid", 32'(rv1), 0);
    cyc(); #3;
    check("s5_wvalid", 32'(wv1), 1);
    check("s5_ivalid", 32'(iv1), 0);
    check("s5_irresp", 32'(irr1), 1);
    check("s5_irdata", ird1, 32'h1234_5678);
    cyc(); ir1 = 1'b0; wr1 = 1'b0; rr1 = 1'b0; #3;

    // Out-of-range load
    cyc(); rr1 = 1'b1; ra1 = 32'h8000_001C; #3;
    check("oor_rvalid", 32'(rv1), 1);
    check("oor_en",     32'(en1), 0);
    check("oor_err",    32'(err1), 1);
    cyc(); rr1 = 1'b0; #3;
    check("oor_err_end", 32'(err1), 0);
    check("oor_drresp",  32'(drr1), 1);
    check("oor_drdata",  drd1, 0);

    // RD_LAT=3: alternating fetch/load grants, responses three cycles later
    cyc(); reset3 = 1'b0; ir3 = 1'b0; #3;
    for (int k = 0; k < 7; k++) begin
      cyc();
      ir3 = 1'b0; rr3 = 1'b0;
      if (k < 4) begin
        if (k % 2 == 0) begin ir3 = 1'b1; ia3 = t5_addr[k]; end
        else begin rr3 = 1'b1; ra3 = t5_addr[k]; end
      end
      #3;
      if (k < 4) begin
        check($sformatf("pl_gnt%0d", k), 32'({iv3, rv3}), (k % 2 == 0) ? 32'h2 : 32'h1);
        check($sformatf("pl_en%0d", k), 32'(en3), 1);
      end
      check($sformatf("pl_irresp%0d", k), 32'(irr3), (k == 3 || k == 5) ? 32'h1 : 32'h0);
      check($sformatf("pl_drresp%0d", k), 32'(drr3), (k == 4 || k == 6) ? 32'h1 : 32'h0);
      check($sformatf("pl_irdata%0d", k), ird3, (k == 3 || k == 5) ? t5_data[k-3] : 32'h0);
      check($sformatf("pl_drdata%0d", k), drd3, (k == 4 || k == 6) ? t5_data[k-3] : 32'h0);
    end

    // Reset with two reads in flight: their responses must never appear
    cyc(); ir3 = 1'b1; ia3 = 32'h0000_0100; #3;
    check("mr_ivalid", 32'(iv3), 1);
    cyc(); ir3 = 1'b0; rr3 = 1'b1; ra3 = 32'h0000_0200; #3;
    check("mr_rvalid", 32'(rv3), 1);
    cyc(); rr3 = 1'b0; ir3 = 1'b1; reset3 = 1'b1; #3;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mr_rst_ivalid%0d", k), 32'(iv3), 0);
      check($sformatf("mr_rst_en%0d", k),     32'(en3), 0);
      check($sformatf("mr_rst_err%0d", k),    32'(err3), 0);
      check($sformatf("mr_rst_rresp%0d", k),  32'({irr3, drr3}), 0);
      if (k == 0) begin cyc(); #3; end
    end
    cyc(); reset3 = 1'b0; ir3 = 1'b0; #3;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mr_quiet%0d", k), 32'({irr3, drr3}), 0);
      cyc(); #3;
    end
    // Normal operation after reset
    ir3 = 1'b1; ia3 = 32'h0000_0300; #1;
    check("mr_resume_ivalid", 32'(iv3), 1);
    cyc(); ir3 = 1'b0; #3;
    cyc(); #3;
    check("mr_resume_early", 32'(irr3), 0);
    cyc(); #3;
    check("mr_resume_rresp", 32'(irr3), 1);
    check("mr_resume_rdata", ird3, 32'h1234_5734);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
